proc_array_ctrl: RTL and testbench

Sequencer for the 2-D systolic processor array used for key evaluation, linear-system construction and Gaussian elimination over GF(2^GF_BIT). It accepts one command at a time and streams the selected rows from an operand buffer into the array's input edge. It drives the edge control signals (op, start, finish, gauss_op, functionA) aligned to the buffer data, waits for the array pipeline to drain, then pulses done. It sits between the top-level scheme FSM and the array's west/north edge.

---
 rtl/proc_array_ctrl_if.sv | 35 +++
 rtl/proc_array_ctrl.sv | 133 +++++++++++++
 tb/tb_proc_array_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/proc_array_ctrl_if.sv
// Command, operand-buffer read and array-edge signals of the systolic array sequencer.
// master = scheme FSM / bench side, slave = proc_array_ctrl.
interface proc_array_ctrl_if #(
   parameter int OP_CODE_LEN = 4,
   parameter int ADDR_W      = 8
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [OP_CODE_LEN-1:0] cmd_op;
   logic                   cmd_funcA;
   logic [ADDR_W-1:0]      cmd_len;
   logic                   abort;
   logic                   rd_en;
   logic [ADDR_W-1:0]      rd_addr;
   logic                   edge_valid;
   logic [OP_CODE_LEN-1:0] op_out;
   logic                   start_out;
   logic                   finish_out;
   logic [1:0]             gauss_op_out;
   logic                   functionA;
   logic                   busy;
   logic                   done;

   modport master (
      output cmd_valid, cmd_op, cmd_funcA, cmd_len, abort,
      input  cmd_ready, rd_en, rd_addr, edge_valid, op_out, start_out,
             finish_out, gauss_op_out, functionA, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_funcA, cmd_len, abort,
      output cmd_ready, rd_en, rd_addr, edge_valid, op_out, start_out,
             finish_out, gauss_op_out, functionA, busy, done
   );
endinterface

// File: rtl/proc_array_ctrl.sv
// Sequencer for the GF(2^m) systolic array: streams len buffer rows into the array edge.
// Latency: done at len+DRAIN_CYC+1 after accept; one command at a time, cmd_ready only in IDLE.
module proc_array_ctrl #(
   parameter int GF_BIT       = 4,
   parameter int OP_CODE_LEN  = 4,
   parameter int ADDR_W       = 8,
   parameter int NUM_PROC_ROW = 4,
   parameter int NUM_PROC_COL = 3
) (
   input logic              clk,
   input logic              rst_n,
   proc_array_ctrl_if.slave bus
);
   localparam int DRAIN_CYC = NUM_PROC_ROW + NUM_PROC_COL + 1;
   localparam int CNT_W     = $clog2(DRAIN_CYC + 1);
   localparam logic [OP_CODE_LEN-1:0] OP_GAUSS = OP_CODE_LEN'(1);
   localparam logic [OP_CODE_LEN-1:0] OP_EVAL  = OP_CODE_LEN'(4);
   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DRAIN_CYC - 1);

   if (GF_BIT != 4 && GF_BIT != 8) begin : g_gf_bit_check
      $error("proc_array_ctrl: GF_BIT must be 4 or 8");
   end

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [ADDR_W-1:0]      len_q, len_d;
   logic [OP_CODE_LEN-1:0] op_q, op_d;
   logic                   funca_q, funca_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   edge_vld_q, edge_vld_d;
   logic                   start_q, start_d;
   logic                   finish_q, finish_d;

   logic rd_en;
   logic last_row;
   logic win;

   assign rd_en    = (state_q == STREAM);
   assign last_row = (addr_q == len_q - 1'b1);
   // Edge window: first registered row through the last drain cycle.
   assign win      = edge_vld_q | (state_q == DRAIN);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      op_d       = op_q;
      funca_d    = funca_q;
      cnt_d      = cnt_q;
      edge_vld_d = rd_en;
      start_d    = rd_en && (addr_q == '0);
      finish_d   = rd_en && last_row;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               funca_d = bus.cmd_funcA;
               len_d   = bus.cmd_len;
               addr_d  = '0;
               cnt_d   = '0;
               state_d = (bus.cmd_len == '0) ? DONE : STREAM;
            end
         end
         STREAM: begin
            if (last_row) begin
               state_d = DRAIN;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort overrides every transition and flushes the registered edge signals.
      if (bus.abort && state_q != IDLE) begin
         state_d    = IDLE;
         addr_d     = '0;
         cnt_d      = '0;
         edge_vld_d = 1'b0;
         start_d    = 1'b0;
         finish_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         op_q       <= '0;
         funca_q    <= 1'b0;
         cnt_q      <= '0;
         edge_vld_q <= 1'b0;
         start_q    <= 1'b0;
         finish_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         op_q       <= op_d;
         funca_q    <= funca_d;
         cnt_q      <= cnt_d;
         edge_vld_q <= edge_vld_d;
         start_q    <= start_d;
         finish_q   <= finish_d;
      end
   end

   assign bus.cmd_ready    = (state_q == IDLE);
   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = (state_q == DONE);
   assign bus.rd_en        = rd_en;
   assign bus.rd_addr      = addr_q;
   assign bus.edge_valid   = edge_vld_q;
   assign bus.start_out    = start_q;
   assign bus.finish_out   = finish_q;
   assign bus.op_out       = win ? op_q : '0;
   assign bus.functionA    = win & funca_q;
   assign bus.gauss_op_out = (win && (op_q == OP_GAUSS || op_q == OP_EVAL)) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_proc_array_ctrl.sv
// Bench for proc_array_ctrl: per-cycle comparison against a timing-table model of the
// active command, plus literal cycle numbers for each directed command.
module tb_proc_array_ctrl;
   localparam int DC = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc;

   proc_array_ctrl_if #(.OP_CODE_LEN(4), .ADDR_W(8)) bus ();

   proc_array_ctrl #(
      .GF_BIT(4), .OP_CODE_LEN(4), .ADDR_W(8), .NUM_PROC_ROW(4), .NUM_PROC_COL(3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Model: one outstanding command, outputs derived from its cycle offset since accept.
   bit       act;
   int       c0;
   int       m_len;
   int       m_op;
   int       m_fa;

   initial begin
      int rel, endc, w;
      int e_rd, e_addr, e_ev, e_st, e_fi, e_win, e_dn, e_busy;
      act = 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            act = 0;
         end else if (act) begin
            endc = (m_len == 0) ? 2 : m_len + DC + 2;
            if (cyc - c0 >= endc) act = 0;
         end
         e_rd = 0; e_addr = 0; e_ev = 0; e_st = 0; e_fi = 0; e_win = 0; e_dn = 0; e_busy = 0;
         if (act) begin
            rel    = cyc - c0;
            e_busy = 1;
            e_rd   = (rel >= 1 && rel <= m_len) ? 1 : 0;
            e_addr = e_rd ? rel - 1 : 0;
            e_ev   = (rel >= 2 && rel <= m_len + 1) ? 1 : 0;
            e_st   = (m_len > 0 && rel == 2) ? 1 : 0;
            e_fi   = (m_len > 0 && rel == m_len + 1) ? 1 : 0;
            e_win  = (m_len > 0 && rel >= 2 && rel <= m_len + DC) ? 1 : 0;
            e_dn   = (rel == ((m_len == 0) ? 1 : m_len + DC + 1)) ? 1 : 0;
         end
         w = e_win;
         chk("cmd_ready", bus.cmd_ready, 1 - e_busy);
         chk("busy", bus.busy, e_busy);
         chk("done", bus.done, e_dn);
         chk("rd_en", bus.rd_en, e_rd);
         chk("rd_addr", bus.rd_addr, e_addr);
         chk("edge_valid", bus.edge_valid, e_ev);
         chk("start_out", bus.start_out, e_st);
         chk("finish_out", bus.finish_out, e_fi);
         chk("op_out", bus.op_out, w ? m_op : 0);
         chk("functionA", bus.functionA, w ? m_fa : 0);
         chk("gauss_op_out", bus.gauss_op_out, (w && (m_op == 1 || m_op == 4)) ? 3 : 0);
         if (rst_n) begin
            if (act && bus.abort) begin
               act = 0;
            end else if (!act && bus.cmd_valid) begin
               act   = 1;
               c0    = cyc;
               m_op  = bus.cmd_op;
               m_fa  = bus.cmd_funcA;
               m_len = bus.cmd_len;
            end
         end
      end
   end

   // Raise cmd_valid with a command and wait for the cycle in which it is accepted.
   task automatic start_cmd(input logic [3:0] op, input logic fa, input logic [7:0] len);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_funcA = fa;
      bus.cmd_len   = len;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept: cmd_ready never seen within 50 cycles");
      end
   endtask

   // Called in cycle 1 of a command; observes cycles 1.. until cmd_ready returns.
   task automatic measure(input int abort_at, output int done_k, output int start_k,
                          output int finish_k, output int rd_cnt, output int ready_k);
      done_k = -1; start_k = -1; finish_k = -1; rd_cnt = 0; ready_k = -1;
      for (int k = 1; k <= 60; k++) begin
         bus.abort = (k == abort_at);
         @(negedge clk);
         if (bus.rd_en) rd_cnt++;
         if (bus.start_out && start_k < 0) start_k = k;
         if (bus.finish_out && finish_k < 0) finish_k = k;
         if (bus.done && done_k < 0) done_k = k;
         if (bus.cmd_ready) begin
            ready_k = k;
            break;
         end
         @(posedge clk); #1;
      end
      bus.abort = 1'b0;
   endtask

   task automatic expect_run(input string tag, input int abort_at, input int x_done,
                             input int x_start, input int x_finish, input int x_rd,
                             input int x_ready);
      int d, s, f, r, rdy;
      measure(abort_at, d, s, f, r, rdy);
      chk({tag, " done cycle"}, d, x_done);
      chk({tag, " start cycle"}, s, x_start);
      chk({tag, " finish cycle"}, f, x_finish);
      chk({tag, " rd_en count"}, r, x_rd);
      chk({tag, " ready cycle"}, rdy, x_ready);
   endtask

   initial begin
      int dn;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 4'd0;
      bus.cmd_funcA = 1'b0;
      bus.cmd_len   = 8'd0;
      bus.abort     = 1'b0;
      #1;
      chk("reset cmd_ready", bus.cmd_ready, 1);
      chk("reset busy", bus.busy, 0);
      chk("reset rd_en", bus.rd_en, 0);
      chk("reset op_out", bus.op_out, 0);
      chk("reset done", bus.done, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // EVAL, len 5
      start_cmd(4'b0100, 1'b0, 8'd5);
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      expect_run("eval5", -1, 14, 2, 6, 5, 15);

      // GAUSS, functionA, len 1
      start_cmd(4'b0001, 1'b1, 8'd1);
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      expect_run("gauss1", -1, 10, 2, 2, 1, 11);

      // MUL_RAND, len 0
      start_cmd(4'b0110, 1'b0, 8'd0);
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      expect_run("mulrand0", -1, 1, -1, -1, 0, 2);

      // EVAL len 3 aborted in its last drain cycle; SHIFT len 2 held on cmd_valid
      start_cmd(4'b0100, 1'b0, 8'd3);
      @(posedge clk); #1;
      bus.cmd_op = 4'b0101; bus.cmd_len = 8'd2;
      expect_run("abort", 11, -1, 2, 4, 3, 12);
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      expect_run("shift2", -1, 11, 2, 3, 2, 12);

      // Back-to-back: KEY_LOAD len 2 then RAND_LOAD len 3 with cmd_valid held
      start_cmd(4'b0011, 1'b0, 8'd2);
      @(posedge clk); #1;
      bus.cmd_op = 4'b0111; bus.cmd_len = 8'd3;
      expect_run("b2b first", -1, 11, 2, 3, 2, 12);
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      expect_run("b2b second", -1, 12, 2, 4, 3, 13);

      // Reset in cycle 3 of EVAL len 5
      start_cmd(4'b0100, 1'b0, 8'd5);
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midreset rd_en", bus.rd_en, 0);
      chk("midreset op_out", bus.op_out, 0);
      chk("midreset busy", bus.busy, 0);
      chk("midreset cmd_ready", bus.cmd_ready, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("midreset no done", dn, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
